vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 clk  input  1  pixel clock, 65 MHz (1024x768 @ 60 Hz); all logic on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 ce  input  1  pixel-advance enable; counters step only on cycles with ce=1.
REQ-004 vga_out  vga_if.out  38 total: vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]; drives the timing stream consumed by the background/drawing chain.
REQ-005 frame_start  output  1  one-cycle pulse registered alongside vga_out when hcount=0 and vcount=0 are presented.
REQ-006 frame_cnt  output  16  frames completed since reset; feature-dependent, see REQ-020.

Function
REQ-007 Internal counters shall be hcnt over 0..1343 and vcnt over 0..805.
REQ-008 On a cycle with ce=1, hcnt shall increment; at 1343 it shall wrap to 0 and vcnt shall step.
REQ-009 When vcnt steps at 805, it shall wrap to 0; every other vcnt step is an increment by 1.
REQ-010 With ce=0, both counters and all outputs shall hold their value; frame_start shall be 0.
REQ-011 All outputs shall be registered, with one clk of latency from counter state to vga_out.
REQ-012 vga_out.hcount/vcount shall equal hcnt/vcnt of the previous cycle, and sync/blank shall be decoded from those same values, so every field is mutually consistent each cycle.
REQ-013 hblnk=1 iff hcount in [1024,1343].
REQ-014 hsync=1 iff hcount in [1048,1183].
REQ-015 vblnk=1 iff vcount in [768,805].
REQ-016 vsync=1 iff vcount in [771,776].
REQ-017 vga_out.rgb shall be 12'h000 at all times; the timing block generates no colour.
REQ-018 frame_start shall be 1 exactly on the registered cycle presenting hcount=0/vcount=0 after a ce=1 advance or after reset release, never twice per frame.
REQ-019 Sync and blank polarity is active-high; any conversion to panel polarity happens downstream.

Configuration
REQ-020 Macro VGA_TIMING_FRAME_CNT_EN: when defined, frame_cnt shall increment by 1 (mod 2^16, 16'hFFFF to 0) on each vcnt wrap 805->0; when undefined, frame_cnt shall be constant 0 and no counter logic is synthesised.

Reset
REQ-021 While rst=1 (asynchronous assert), hcnt, vcnt, every vga_out field, and frame_cnt shall be 0, and frame_start shall be 0.
REQ-022 On the first clk edge after rst deassertion, outputs shall present hcount=0/vcount=0 with frame_start=1.
REQ-023 Counting from 0 shall begin on the first ce=1 cycle after reset.
REQ-024 Reset mid-line or mid-frame shall abandon the current frame; no partial-frame increment of frame_cnt.

Structure
REQ-025 vga_pkg shall hold HOR_PIXELS=1024 and VER_PIXELS=768.
REQ-026 vga_pkg shall hold HOR_TOTAL_TIME=1344, HOR_SYNC_START=1048, and HOR_SYNC_TIME=136.
REQ-027 vga_pkg shall hold VER_TOTAL_TIME=806, VER_SYNC_START=771, and VER_SYNC_TIME=6.
REQ-028 All decode shall use these constants, with no literals in RTL.
REQ-029 No sub-module is required; the counters and decode are flat in vga_timing.

Verification
REQ-030 Reset then ce=1 continuously -> cycle 1 after release: hcount=0, vcount=0, frame_start=1; hsync rises exactly when hcount=1048 and falls at 1184; hblnk rises at hcount=1024.
REQ-031 Run 2 full frames (2x1,083,264 ce cycles) -> hcount 1343->0 with vcount+1; vcount 805->0; vsync=1 only for vcount 771..776; exactly 2 frame_start pulses 1,083,264 cycles apart.
REQ-032 ce toggled 1,0,0,1 around hcount=1343/vcount=805 -> outputs hold through the ce=0 cycles; wrap to 0/0 occurs only on the next ce=1; frame_start high once.
REQ-033 With VGA_TIMING_FRAME_CNT_EN, frame_cnt forced through 65,536 frames (or initialised near 16'hFFFE in a test build) -> FFFE->FFFF->0000. Without the macro, frame_cnt stays 0.
REQ-034 rst asserted asynchronously at hcount=500/vcount=400 -> all outputs 0 immediately without waiting for clk; after release the REQ-022 sequence repeats and frame_cnt stays 0.
REQ-035 Continuous check for every cycle: rgb=000; hblnk equals (hcount>=1024); vblnk equals (vcount>=768); no X on any output after reset.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 1024x768@60 timing constants, counter type and sync/blank decode helper.
// Pure constants and a combinational function; no state, no latency.
// No flow control; consumers sample the decode result directly.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HOR_PIXELS     = 11'd1024;
  localparam cnt_t VER_PIXELS     = 11'd768;
  localparam cnt_t HOR_TOTAL_TIME = 11'd1344;
  localparam cnt_t HOR_SYNC_START = 11'd1048;
  localparam cnt_t HOR_SYNC_TIME  = 11'd136;
  localparam cnt_t VER_TOTAL_TIME = 11'd806;
  localparam cnt_t VER_SYNC_START = 11'd771;
  localparam cnt_t VER_SYNC_TIME  = 11'd6;

  // Derived bounds: last count value, and first count past the sync pulse.
  localparam cnt_t HOR_LAST     = HOR_TOTAL_TIME - 11'd1;
  localparam cnt_t VER_LAST     = VER_TOTAL_TIME - 11'd1;
  localparam cnt_t HOR_SYNC_END = HOR_SYNC_START + HOR_SYNC_TIME;
  localparam cnt_t VER_SYNC_END = VER_SYNC_START + VER_SYNC_TIME;

  typedef struct packed {
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
  } sync_t;

  // Active-high sync/blank for a given counter position.
  function automatic sync_t decode(cnt_t h, cnt_t v);
    sync_t s;
    s.hblnk = (h >= HOR_PIXELS);
    s.hsync = (h >= HOR_SYNC_START) && (h < HOR_SYNC_END);
    s.vblnk = (v >= VER_PIXELS);
    s.vsync = (v >= VER_SYNC_START) && (v < VER_SYNC_END);
    return s;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Timing stream bundle passed from the timing block to the drawing chain.
// Wires only; latency is set by the producer.
// No backpressure; the stream advances under the producer's pixel enable.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// VGA 1024x768 timing generator: h/v counters with registered sync/blank stream.
// One clk from counter state to vga_out; frame_start aligned with hcount=vcount=0.
// No backpressure; ce=0 freezes everything. Optional frame counter: VGA_TIMING_FRAME_CNT_EN.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  cnt_t  hcnt;
  cnt_t  vcnt;
  logic  line_end;
  logic  at_origin;
  logic  boot;       // first edge after reset release
  logic  boot_held;  // origin already announced by the boot pulse, counters not yet moved
  sync_t dec;

  assign line_end  = (hcnt == HOR_LAST);
  assign at_origin = (hcnt == '0) && (vcnt == '0);
  assign dec       = decode(hcnt, vcnt);

  // Pixel/line counters, stepping only on ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= (vcnt == VER_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Output register: position and its decode are captured together so fields always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
    end else if (ce) begin
      vga_out.hcount <= hcnt;
      vga_out.vcount <= vcnt;
      vga_out.hsync  <= dec.hsync;
      vga_out.hblnk  <= dec.hblnk;
      vga_out.vsync  <= dec.vsync;
      vga_out.vblnk  <= dec.vblnk;
    end
  end

  // The timing block never generates colour.
  assign vga_out.rgb = '0;

  // Frame-start pulse: once on the first edge after reset, then on each ce advance presenting
  // the origin; if the boot pulse fired with ce=0 the first real origin advance is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
      boot        <= 1'b1;
      boot_held   <= 1'b0;
    end else begin
      boot        <= 1'b0;
      frame_start <= boot || (ce && at_origin && !boot_held);
      if (ce) begin
        boot_held <= 1'b0;
      end else if (boot) begin
        boot_held <= 1'b1;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic frame_end;
  assign frame_end = line_end && (vcnt == VER_LAST);

  // Completed-frame counter, stepping on each vertical wrap; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (ce && frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
